// File: rtl/mux4_pkg.sv
// Shared constants and types for the 4:1 mux round-robin select controller.
package mux4_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic [0:0] {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod 4.
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic [SEL_W-1:0]  pick,
  output logic              found
);

  logic [SEL_W-1:0] idx;

  // Scan ascending from ptr; the first hit wins.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_sel_ctrl.sv
// Round-robin select controller for a 4:1 mux with bounded hold time and
// a registered, channel-tagged capture of the mux output.
module mux4_rr_sel_ctrl
  import mux4_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CW       = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              z,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] gnt,
  output logic              gnt_vld,
  output logic              z_q,
  output logic [SEL_W-1:0]  z_ch,
  output logic              z_vld
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CW-1:0]    cnt;

  logic             active;
  logic             hold_done;
  logic             rel;
  logic [SEL_W-1:0] scan_ptr;
  logic [SEL_W-1:0] pick;
  logic             found;

  // Release decision; on release the picker scans from just past the current
  // channel so it drops to lowest priority within the same cycle.
  always_comb begin
    active    = req[sel];
    hold_done = (cnt == CW'(MAX_HOLD));
    rel       = (state == GRANT) && (!active || hold_done);
    scan_ptr  = (state == GRANT) ? sel + SEL_W'(1) : ptr;
  end

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (scan_ptr),
    .pick  (pick),
    .found (found)
  );

  // Arbitration FSM with registered select/grant outputs and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      sel     <= '0;
      gnt     <= '0;
      gnt_vld <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state   <= GRANT;
            sel     <= pick;
            gnt     <= NUM_CH'(1) << pick;
            gnt_vld <= 1'b1;
            cnt     <= CW'(1);
          end
        end
        GRANT: begin
          if (!rel) begin
            cnt <= cnt + CW'(1);
          end else begin
            ptr <= sel + SEL_W'(1);
            if (found) begin
              sel <= pick;
              gnt <= NUM_CH'(1) << pick;
              cnt <= CW'(1);
            end else begin
              state   <= IDLE;
              gnt     <= '0;
              gnt_vld <= 1'b0;
              cnt     <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the mux output one cycle late, only for cycles the granted channel still requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_vld <= 1'b0;
      z_q   <= 1'b0;
      z_ch  <= '0;
    end else begin
      z_vld <= gnt_vld & active;
      if (gnt_vld & active) begin
        z_q  <= z;
        z_ch <= sel;
      end
    end
  end

endmodule

// File: doc/mux4_rr_sel_ctrl.md
Name: mux4_rr_sel_ctrl

Overview:
Round-robin select controller that sits directly upstream of the 4:1 mux (mux4_to_1). It drives the mux `sel[1:0]`, arbitrating among four requesting channels with a bounded hold time. It also registers the mux output `z` back, tagged with the channel it came from. It replaces free-running select toggling with a request-driven, fair scan.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one channel keeps the grant; legal range 1..2^CW-1.
- CW, 8, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-channel request; bit i requests mux input din[i].
- z  input  1  mux output, combinationally a function of `sel`.
- sel  output  2  select to mux; registered.
- gnt  output  4  one-hot grant, equal to 1<<sel when gnt_vld=1, else 0; registered.
- gnt_vld  output  1  a grant is active this cycle; registered.
- z_q  output  1  captured mux output.
- z_ch  output  2  channel index z_q was captured from.
- z_vld  output  1  z_q/z_ch valid this cycle (single-cycle pulse per sample).

Behaviour:
- Reset (async assert, sync-free release): sel=0, gnt=0, gnt_vld=0, z_q=0, z_ch=0, z_vld=0.
  - Internal state: state=IDLE, ptr=0, cnt=0.
- Picker (combinational): scans req starting at index ptr, ascending, mod 4. It returns the first set bit and a found flag.
- State IDLE (gnt_vld=0):
  - found=1 -> next cycle: state=GRANT, sel=pick, gnt=1<<pick, gnt_vld=1, cnt=1.
  - found=0 -> remain IDLE; sel holds its last value.
- State GRANT (gnt_vld=1), per cycle:
  - Active cycle: `req[sel]=1`.
  - Release condition: `req[sel]=0` OR `cnt==MAX_HOLD`.
  - No release: cnt<=cnt+1; sel/gnt unchanged.
  - Release: ptr<=sel+1 (2-bit wrap, so 3->0), and the picker is evaluated with this new ptr in the same cycle. The current channel therefore becomes lowest priority.
    - found=1 -> back-to-back grant next cycle (may be the same channel if it is the only requester): sel=pick, cnt=1, gnt_vld stays 1. No idle bubble.
    - found=0 -> next cycle IDLE: gnt=0, gnt_vld=0, cnt=0.
- Sample path, one-cycle latency:
  - Every clock: z_vld <= gnt_vld & req[sel].
  - When that term is 1: z_q<=z, z_ch<=sel.
  - Otherwise z_q/z_ch hold their values.
  - A cycle where the granted request has already dropped produces no sample.
- Counting: cnt saturates logically at MAX_HOLD; it never exceeds it and never wraps.
  - MAX_HOLD=1 gives strict per-cycle round-robin.
- Simultaneous events:
  - Hold expiry and req drop in the same cycle: treated as a single release.
  - New requests that arrive during a release cycle participate in that cycle's pick.
- Reset mid-grant: all outputs clear immediately (asynchronous); no sample is emitted for the interrupted cycle. After release, arbitration restarts from ptr=0.
- Fairness guarantee: with all four requesting continuously, grants rotate 0,1,2,3,0…, each held exactly MAX_HOLD cycles.

Decomposition:
- Package mux4_pkg:
  - NUM_CH=4, SEL_W=2.
  - State enum {IDLE, GRANT}.
- Sub-module rr_pick4 (combinational): inputs req[3:0], ptr[1:0]; outputs pick[1:0], found.
- Top holds the FSM, counter, ptr, and the sample registers.

Test Plan:
1. Reset, then req=4'b0000 for 10 cycles -> sel=0, gnt_vld=0, z_vld=0 throughout.
2. MAX_HOLD=4; req=4'b1111 held; mux din=4'hb -> sel sequence 0×4, 1×4, 2×4, 3×4, 0…; gnt_vld continuously 1; z_vld=1 one cycle after each grant cycle; (z_q, z_ch) = (1,0),(1,1),(0,2),(1,3).
3. Only req[2]=1, held 12 cycles -> sel=2 throughout with no gnt_vld gap at hold expiry; cnt reload visible every 4 cycles; 12 samples, all with z_ch=2.
4. req=4'b0011; drop req[0] on the second granted cycle -> release; sel=1 on the next cycle without a bubble. The dropped cycle yields z_vld=0.
5. req[3] granted, then req[3] drops while req=4'b0001 -> ptr wraps to 0; sel=0 next cycle.
6. Assert rst_n=0 mid-grant (sel=1, cnt=2) -> sel, gnt, gnt_vld, z_vld go to 0 immediately. After release with req=4'b0110, the first grant goes to sel=1 (ptr reset to 0).
